// File: rtl/pov_pkg.sv
// Shared FSM state encoding, default geometry and width helper for the POV column driver.
package pov_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } pov_state_t;

  localparam int unsigned DEF_LED_N    = 16;
  localparam int unsigned DEF_NUM_COLS = 180;
  localparam int unsigned DEF_CLK_DIV  = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pov_edge_det.sv
// One-bit rising-edge detector; registered history, combinational strobe.
module pov_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pov_column_driver.sv
// POV column driver: turns timer strobes into frame-memory fetches and serial LED-chain loads.
// Optional build macro POV_BLANK_EN blanks the LEDs (oe_n=1) while a column is loaded and shifted.
module pov_column_driver
  import pov_pkg::*;
#(
  parameter int unsigned LED_N    = DEF_LED_N,
  parameter int unsigned COL_W    = 8,
  parameter int unsigned NUM_COLS = DEF_NUM_COLS,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic             cycend,
  input  logic             beg,
  input  logic [LED_N-1:0] mem_data,
  output logic [COL_W-1:0] col_addr,
  output logic             mem_rd,
  output logic             ser_dat,
  output logic             ser_clk,
  output logic             ser_lat,
  output logic             oe_n,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned BIT_W = clog2(LED_N);
  localparam int unsigned DIV_W = clog2(CLK_DIV + 1);

  pov_state_t state, state_nxt;

  logic             tick, wrap, resync;
  logic [LED_N-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             div_done, timing;
  logic [COL_W-1:0] col_idx, col_nxt;
  logic             skip_adv;
  logic             oe_hold;
  logic             fetch, load, shift, latch_done;

  pov_edge_det u_ready_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (ready),
    .rise (tick)
  );

  pov_edge_det u_cycend_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (cycend),
    .rise (wrap)
  );

  assign resync   = wrap | beg;
  assign timing   = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LATCH);
  assign div_done = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign col_nxt  = (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + COL_W'(1);
  assign ser_dat  = shreg[LED_N-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fetch      = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    latch_done = 1'b0;
    ser_clk    = 1'b0;
    ser_lat    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (tick) begin
          fetch     = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        load      = 1'b1;
        state_nxt = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (div_done) state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        ser_clk = 1'b1;
        if (div_done) begin
          if (bit_cnt == '0) begin
            state_nxt = LATCH;
          end else begin
            shift     = 1'b1;
            state_nxt = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        ser_lat = 1'b1;
        if (div_done) begin
          latch_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_addr <= '0;
      mem_rd   <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      overrun  <= 1'b0;
    end else begin
      mem_rd <= fetch;
      // a resync coinciding with the fetch already forces the address to column 0
      if (fetch) col_addr <= resync ? '0 : col_idx;
      if (load) begin
        shreg   <= mem_data;
        bit_cnt <= BIT_W'(LED_N - 1);
      end else if (shift) begin
        shreg   <= {shreg[LED_N-2:0], 1'b0};
        bit_cnt <= bit_cnt - BIT_W'(1);
      end
      div_cnt <= (!timing || div_done) ? '0 : div_cnt + DIV_W'(1);
      if (tick && busy) overrun <= 1'b1;
    end
  end

  // A resync during a column zeroes the index now and holds it there when that column latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_idx  <= '0;
      skip_adv <= 1'b0;
    end else if (resync) begin
      col_idx  <= '0;
      skip_adv <= busy && !latch_done;
    end else if (latch_done) begin
      if (!skip_adv) col_idx <= col_nxt;
      skip_adv <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) oe_hold <= 1'b1;
    else      oe_hold <= 1'b0;
  end

`ifdef POV_BLANK_EN
  assign oe_n = oe_hold | (state == LOAD) | (state == SHIFT_LO) |
                (state == SHIFT_HI) | (state == LATCH);
`else
  assign oe_n = oe_hold;
`endif

endmodule

// File: tb/tb_pov_column_driver.sv
// Directed self-checking bench for pov_column_driver (LED_N=16, NUM_COLS=180, CLK_DIV=2).
module tb_pov_column_driver;

`ifdef POV_BLANK_EN
  localparam int OE_EXP = 67;
`else
  localparam int OE_EXP = 0;
`endif

  logic        clk, rst, ready, cycend, beg;
  logic [15:0] mem_data;
  logic [7:0]  col_addr;
  logic        mem_rd, ser_dat, ser_clk, ser_lat, oe_n, busy, overrun;

  int vectors = 0;
  int miscompares = 0;

  logic        use_fixed;
  logic [15:0] fixed_word;
  logic [7:0]  fetch_q[$];
  int          sclk_rises, lat_cyc, oe_hi;
  logic [15:0] cap;
  logic        sclk_prev;

  pov_column_driver #(
    .LED_N    (16),
    .COL_W    (8),
    .NUM_COLS (180),
    .CLK_DIV  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .cycend   (cycend),
    .beg      (beg),
    .mem_data (mem_data),
    .col_addr (col_addr),
    .mem_rd   (mem_rd),
    .ser_dat  (ser_dat),
    .ser_clk  (ser_clk),
    .ser_lat  (ser_lat),
    .oe_n     (oe_n),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  always @(posedge clk) mem_data <= use_fixed ? fixed_word : word_of(col_addr);

  always @(negedge clk) begin
    if (mem_rd) fetch_q.push_back(col_addr);
    if (ser_clk && !sclk_prev) begin
      sclk_rises++;
      cap = {cap[14:0], ser_dat};
    end
    sclk_prev = ser_clk;
    if (ser_lat) lat_cyc++;
    if (oe_n && rst) oe_hi++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    fetch_q.delete();
    sclk_rises = 0;
    lat_cyc    = 0;
    oe_hi      = 0;
    cap        = '0;
  endtask

  function automatic logic [31:0] first_fetch();
    return (fetch_q.size() == 1) ? {24'd0, fetch_q[0]} : 32'hFFFF_FFFF;
  endfunction

  task automatic tick_col(input int gap);
    clear_mon();
    @(negedge clk) ready = 1'b1;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    repeat (gap - 3) @(negedge clk);
  endtask

  initial begin
    int n;
    int ea;
    bit seen, done;

    rst = 1'b0; ready = 1'b0; cycend = 1'b0; beg = 1'b0;
    use_fixed = 1'b0; fixed_word = '0; sclk_prev = 1'b0;
    sclk_rises = 0; lat_cyc = 0; oe_hi = 0; cap = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_col_addr", col_addr, 0);
    chk("rst_ser_clk", ser_clk, 0);
    chk("rst_ser_lat", ser_lat, 0);
    chk("rst_ser_dat", ser_dat, 0);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_overrun", overrun, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("oe_after_rst", oe_n, 0);

    // single column, fixed word: bit order, clock count, latch width and latency
    use_fixed = 1'b1; fixed_word = 16'hA5C3;
    clear_mon();
    @(negedge clk) ready = 1'b1;
    n = 0; seen = 0; done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 3) ready = 1'b0;
      if (ser_lat) seen = 1;
      else if (seen) done = 1;
    end
    repeat (2) @(negedge clk);
    chk("latch_fall_latency", n, 69);
    chk("ser_clk_rises", sclk_rises, 16);
    chk("ser_bits", cap, 16'hA5C3);
    chk("ser_lat_width", lat_cyc, 2);
    chk("fetch_addr_first", first_fetch(), 0);
    chk("oe_blank_cycles", oe_hi, OE_EXP);
    chk("idle_busy", busy, 0);
    use_fixed = 1'b0;
    repeat (30) @(negedge clk);

    // full revolution of ticks, index wraps after 179
    ea = 1;
    for (int i = 0; i < 181; i++) begin
      tick_col(100);
      chk("fetch_addr_rev", first_fetch(), ea);
      ea = (ea + 1) % 180;
    end
    chk("overrun_clean", overrun, 0);

    // advance to column 57, then cycend mid-shift
    while (ea != 57) begin
      tick_col(100);
      ea = ea + 1;
    end
    clear_mon();
    @(negedge clk) ready = 1'b1;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    repeat (27) @(negedge clk);
    chk("mid_shift_busy", busy, 1);
    cycend = 1'b1;
    repeat (2) @(negedge clk);
    cycend = 1'b0;
    repeat (68) @(negedge clk);
    chk("col57_addr", first_fetch(), 57);
    chk("col57_bits", cap, word_of(8'd57));
    chk("col57_rises", sclk_rises, 16);
    chk("col57_latch", lat_cyc, 2);
    tick_col(100);
    chk("after_wrap_addr", first_fetch(), 0);
    tick_col(100);
    chk("after_wrap_next", first_fetch(), 1);

    // tick and cycend in the same IDLE cycle
    clear_mon();
    @(negedge clk) begin ready = 1'b1; cycend = 1'b1; end
    repeat (3) @(negedge clk);
    ready = 1'b0; cycend = 1'b0;
    repeat (97) @(negedge clk);
    chk("tick_wrap_addr", first_fetch(), 0);
    tick_col(100);
    chk("tick_wrap_next", first_fetch(), 1);

    // beg level in IDLE realigns to column 0
    @(negedge clk) beg = 1'b1;
    @(negedge clk) beg = 1'b0;
    tick_col(100);
    chk("beg_addr", first_fetch(), 0);

    // second ready edge while busy is dropped and flagged
    clear_mon();
    @(negedge clk) ready = 1'b1;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    repeat (17) @(negedge clk);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    repeat (97) @(negedge clk);
    chk("overrun_fetches", fetch_q.size(), 1);
    chk("overrun_addr", first_fetch(), 1);
    chk("overrun_set", overrun, 1);
    tick_col(100);
    chk("overrun_next_addr", first_fetch(), 2);
    chk("overrun_sticky", overrun, 1);

    // asynchronous reset while the chain clock is high
    clear_mon();
    @(negedge clk) ready = 1'b1;
    n = 0;
    while (!ser_clk && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 3) ready = 1'b0;
    end
    ready = 1'b0;
    chk("reach_shift_hi", ser_clk, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ser_clk", ser_clk, 0);
    chk("arst_ser_lat", ser_lat, 0);
    chk("arst_ser_dat", ser_dat, 0);
    chk("arst_mem_rd", mem_rd, 0);
    chk("arst_col_addr", col_addr, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_oe_n", oe_n, 1);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    tick_col(100);
    chk("post_rst_addr", first_fetch(), 0);
    tick_col(100);
    chk("post_rst_next", first_fetch(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pov_column_driver.md
Name: pov_column_driver

Overview:
- Downstream consumer of the POV rotation timer: converts its ready (column slot) and cycend (end of revolution) strobes into column fetches from the frame memory.
- Serially shifts each fetched column word into the external LED shift-register chain and latches it.
- Keeps the column index aligned to the revolution; flags timing overruns.

Parameters:
LED_N, 16, LEDs per column = bits shifted per column (2..32)
COL_W, 8, width of the column address
NUM_COLS, 180, columns per revolution; index wraps at NUM_COLS-1
CLK_DIV, 2, clk cycles per ser_clk half-period (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
ready  input  1  column-slot strobe from timer (level; rising edge = tick)
cycend  input  1  end-of-revolution flag from timer (rising edge = wrap)
beg  input  1  revolution start (sensor index), synchronous level
mem_data  input  LED_N  column word, valid 1 cycle after col_addr/mem_rd
col_addr  output  COL_W  column address to frame memory
mem_rd  output  1  one-cycle read strobe
ser_dat  output  1  serial data to LED chain, MSB first
ser_clk  output  1  shift clock to LED chain
ser_lat  output  1  latch pulse, CLK_DIV cycles wide
oe_n  output  1  LED output enable, active-low
busy  output  1  high whenever FSM not IDLE
overrun  output  1  sticky: tick arrived while busy

Behaviour:
- Reset (rst=0, async): state IDLE; col_idx=0; col_addr=0; mem_rd=0; ser_dat=0; ser_clk=0; ser_lat=0; oe_n=1; busy=0; overrun=0; edge-detect history=0.
- Edge detect: tick = ready & ~ready_q; wrap = cycend & ~cycend_q; both registered history, 1 cycle latency.
- FSM states: IDLE -> FETCH -> LOAD -> SHIFT_LO <-> SHIFT_HI -> LATCH -> IDLE.
- IDLE: on tick, col_addr<=col_idx, mem_rd=1 for one cycle, go FETCH.
- FETCH: wait one cycle (memory latency); go LOAD.
- LOAD: shreg<=mem_data; bit_cnt<=LED_N-1; ser_dat<=mem_data[LED_N-1]; go SHIFT_LO.
- SHIFT_LO: ser_clk=0 for CLK_DIV cycles, then SHIFT_HI.
- SHIFT_HI: ser_clk=1 for CLK_DIV cycles; on exit, if bit_cnt==0 go LATCH, else shift left, ser_dat<=next MSB, bit_cnt-1, go SHIFT_LO.
- LATCH: ser_clk=0, ser_lat=1 for CLK_DIV cycles; on exit ser_lat=0, col_idx advances, go IDLE.
- Index advance: col_idx==NUM_COLS-1 -> 0, else +1.
- Tick-to-latch-fall latency: 2 + 2*LED_N*CLK_DIV + CLK_DIV cycles after tick detected.
- wrap or beg: col_idx<=0 immediately (any state); in-progress column completes with its already-fetched data; the advance at the end of LATCH is suppressed that cycle so the next column is 0.
- wrap/beg same cycle as LATCH exit: col_idx ends at 0.
- tick while busy: dropped, overrun<=1 (sticky until reset); FSM unaffected.
- tick and wrap same cycle in IDLE: fetch uses address 0, then col_idx=1.
- busy = (state != IDLE).
- oe_n: 0 from the first cycle after reset release unless POV_BLANK_EN.

Optional Feature:
- Macro POV_BLANK_EN.
- Defined: oe_n=1 during LOAD, SHIFT_*, and LATCH; returns 0 the cycle after LATCH exits; all LEDs dark while the chain shifts.
- Undefined: oe_n=0 permanently after reset; no blanking logic synthesised.

Decomposition:
- Package pov_pkg: FSM state enum (IDLE, FETCH, LOAD, SHIFT_LO, SHIFT_HI, LATCH); default constants for LED_N, NUM_COLS, CLK_DIV; function clog2 for counter widths.
- Sub-module pov_edge_det: one-bit rising-edge detector with async active-low reset; instantiated for ready and cycend.

Test Plan:
- Reset mid-SHIFT_HI (LED_N=16, CLK_DIV=2): assert rst=0 -> all outputs at reset values same cycle; col_idx=0.
- Single tick, mem_data=16'hA5C3 -> 16 ser_clk rising edges, ser_dat=1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 sampled at rising edges; ser_lat high 2 cycles; latch falls 69 cycles after tick detection; col_addr=0.
- 180 ticks spaced 100 cycles, no cycend -> col_addr 0..179 on successive fetches, 181st fetch uses 0; overrun stays 0.
- cycend rising edge while column 57 is shifting -> column 57 completes; next fetch col_addr=0.
- Second ready edge 20 cycles after first (busy) -> no extra fetch; overrun=1 and stays 1 through later ticks.
- With POV_BLANK_EN: oe_n=1 from LOAD through LATCH, 0 otherwise; without it oe_n=0 throughout the same run.
